led_pattern_gen: RTL and testbench

Parametrised successor to the free-running counter LED blinker. Drives NUM_LEDS board LEDs from one clock through a programmable prescaler, with four runtime-selectable modes: binary count, bouncing scanner, PWM breathing and off. Sits directly between the board oscillator pin and the LED pins. Serves as the standard status/heartbeat indicator for iCE40 top levels.

---
 rtl/led_pattern_gen.sv | 177 +++++++++++++++++
 tb/tb_led_pattern_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled LED pattern generator with four runtime modes
// (binary count, bouncing scanner, PWM breathing, off) for board status LEDs.
// Optional build macro LED_GAMMA_EN squares the breathing duty for a
// perceptually linear fade; without it the duty drives the PWM directly.

module led_pattern_gen #(
    parameter int NUM_LEDS   = 5,
    parameter int PRESC_W    = 24,
    parameter int DIV        = 262144,
    parameter int PWM_W      = 8,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                hwclk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] led,
    output logic                tick
);

    localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(DIV - 1);
    localparam logic [POS_W-1:0]    POS_LAST   = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0]    POS_TURN   = POS_W'((NUM_LEDS > 1) ? NUM_LEDS - 2 : 0);
    localparam logic [PWM_W-1:0]    DUTY_MAX   = '1;
    localparam logic [NUM_LEDS-1:0] ONE_HOT0   = NUM_LEDS'(1);
    localparam logic                DIR_UP     = 1'b0;
    localparam logic                DIR_DOWN   = 1'b1;

    typedef enum logic [1:0] {
        MODE_BINARY  = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_OFF     = 2'd3
    } mode_t;

    mode_t               mode_q;
    logic [PRESC_W-1:0]  presc;
    logic [NUM_LEDS-1:0] cnt, cnt_nxt;
    logic [POS_W-1:0]    pos, pos_nxt;
    logic                sdir, sdir_nxt;
    logic [PWM_W-1:0]    duty, duty_nxt;
    logic                bdir, bdir_nxt;
    logic [PWM_W-1:0]    pwm_cnt;
    logic [PWM_W-1:0]    duty_eff;
    logic [NUM_LEDS-1:0] pattern;
    logic                mode_chg;
    logic                strobe;
    logic                step;

    // A mode change restarts the pattern and swallows any strobe that cycle
    assign mode_chg = (mode != mode_q);
    assign strobe   = enable && (presc == PRESC_LAST);
    assign step     = strobe && !mode_chg;

`ifdef LED_GAMMA_EN
    logic [2*PWM_W-1:0] duty_sq;
    assign duty_sq  = {{PWM_W{1'b0}}, duty} * {{PWM_W{1'b0}}, duty};
    assign duty_eff = duty_sq[2*PWM_W-1:PWM_W];
`else
    assign duty_eff = duty;
`endif

    // Prescaler, registered mode and the tick pulse that follows each step
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            mode_q <= MODE_BINARY;
            tick   <= 1'b0;
        end else begin
            tick <= step;
            if (mode_chg) begin
                mode_q <= mode_t'(mode);
                presc  <= '0;
            end else if (enable) begin
                presc <= strobe ? '0 : presc + 1'b1;
            end
        end
    end

    // Next step state: restart on mode change, otherwise advance the active mode
    always_comb begin
        cnt_nxt  = cnt;
        pos_nxt  = pos;
        sdir_nxt = sdir;
        duty_nxt = duty;
        bdir_nxt = bdir;
        if (mode_chg) begin
            cnt_nxt  = '0;
            pos_nxt  = '0;
            sdir_nxt = DIR_UP;
            duty_nxt = '0;
            bdir_nxt = DIR_UP;
        end else if (step) begin
            case (mode_q)
                MODE_BINARY: cnt_nxt = cnt + 1'b1;
                MODE_SCAN: begin
                    if (NUM_LEDS > 1) begin
                        if (sdir == DIR_UP && pos == POS_LAST) begin
                            sdir_nxt = DIR_DOWN;
                            pos_nxt  = POS_TURN;
                        end else if (sdir == DIR_DOWN && pos == '0) begin
                            sdir_nxt = DIR_UP;
                            pos_nxt  = POS_W'(1);
                        end else if (sdir == DIR_UP) begin
                            pos_nxt = pos + 1'b1;
                        end else begin
                            pos_nxt = pos - 1'b1;
                        end
                    end
                end
                MODE_BREATHE: begin
                    if (bdir == DIR_UP && duty == DUTY_MAX) begin
                        bdir_nxt = DIR_DOWN;
                        duty_nxt = DUTY_MAX - 1'b1;
                    end else if (bdir == DIR_DOWN && duty == '0) begin
                        bdir_nxt = DIR_UP;
                        duty_nxt = PWM_W'(1);
                    end else if (bdir == DIR_UP) begin
                        duty_nxt = duty + 1'b1;
                    end else begin
                        duty_nxt = duty - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Step state register
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            pos  <= '0;
            sdir <= DIR_UP;
            duty <= '0;
            bdir <= DIR_UP;
        end else begin
            cnt  <= cnt_nxt;
            pos  <= pos_nxt;
            sdir <= sdir_nxt;
            duty <= duty_nxt;
            bdir <= bdir_nxt;
        end
    end

    // Free-running PWM counter, kept running while frozen so breathing stays visible
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // Lit pattern for the registered mode (1 = lit)
    always_comb begin
        pattern = '0;
        case (mode_q)
            MODE_BINARY:  pattern = cnt;
            MODE_SCAN:    pattern = ONE_HOT0 << pos;
            MODE_BREATHE: pattern = {NUM_LEDS{pwm_cnt < duty_eff}};
            default:      pattern = '0;
        endcase
    end

    // LED output register, inverted for boards that sink LED current
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            led <= (ACTIVE_LOW != 0) ? '1 : '0;
        end else begin
            led <= (ACTIVE_LOW != 0) ? ~pattern : pattern;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed self-checking bench for led_pattern_gen
// (NUM_LEDS=5, DIV=4, PWM_W=4, active-high LEDs). Expected breathing counts
// follow LED_GAMMA_EN when the bench is built with that macro.

module tb_led_pattern_gen;

    logic       hwclk;
    logic       rst_n;
    logic       enable;
    logic [1:0] mode;
    logic [4:0] led;
    logic       tick;

    int checks = 0;
    int errors = 0;

    led_pattern_gen #(
        .NUM_LEDS  (5),
        .PRESC_W   (8),
        .DIV       (4),
        .PWM_W     (4),
        .ACTIVE_LOW(0)
    ) dut (
        .hwclk (hwclk),
        .rst_n (rst_n),
        .enable(enable),
        .mode  (mode),
        .led   (led),
        .tick  (tick)
    );

`ifdef LED_GAMMA_EN
    localparam int LIT_D3  = 0;
    localparam int LIT_D5  = 1;
    localparam int LIT_D15 = 14;
    localparam int LIT_D14 = 12;
    localparam int LIT_D1  = 0;
`else
    localparam int LIT_D3  = 3;
    localparam int LIT_D5  = 5;
    localparam int LIT_D15 = 15;
    localparam int LIT_D14 = 14;
    localparam int LIT_D1  = 1;
`endif

    // 100 MHz board clock
    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    // Guard against a stuck run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic stepClk();
        @(posedge hwclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] md);
        enable = en;
        mode   = md;
    endtask

    // Hold reset over two edges, then release mid-cycle
    task automatic resetDut(input logic en, input logic [1:0] md);
        rst_n = 1'b0;
        applyStimulus(en, md);
        stepClk();
        stepClk();
        rst_n = 1'b1;
    endtask

    // Run exactly n strobes from presc=0, then freeze
    task automatic advanceStrobes(input int n);
        enable = 1'b1;
        repeat (4 * n) stepClk();
        enable = 1'b0;
    endtask

    // Count fully lit cycles over one 16-cycle PWM window
    task automatic countLit(output int n);
        n = 0;
        repeat (16) begin
            stepClk();
            if (led == 5'h1F) n++;
        end
    endtask

    logic [4:0] scanExp [10];
    int         lit;

    initial begin
        scanExp = '{5'h02, 5'h04, 5'h08, 5'h10, 5'h08, 5'h04, 5'h02, 5'h01, 5'h02, 5'h04};
        rst_n  = 1'b0;
        enable = 1'b1;
        mode   = 2'd0;

        // Reset state and binary counting with wrap
        resetDut(1'b1, 2'd0);
        checkOutput("reset_led", 32'(led), 32'h0);
        checkOutput("reset_tick", 32'(tick), 32'h0);
        for (int k = 1; k <= 33; k++) begin
            stepClk();
            checkOutput("bin_led", 32'(led), 32'((k - 1) % 32));
            checkOutput("bin_tick_lo", 32'(tick), 32'h0);
            stepClk();
            stepClk();
            stepClk();
            checkOutput("bin_tick_hi", 32'(tick), 32'h1);
        end

        // Mode change restarts count and prescaler
        resetDut(1'b1, 2'd0);
        repeat (29) stepClk();
        checkOutput("mc_cnt7", 32'(led), 32'h7);
        mode = 2'd1;
        stepClk();
        checkOutput("mc_led_lag", 32'(led), 32'h7);
        stepClk();
        checkOutput("mc_scan_led", 32'(led), 32'h1);
        mode = 2'd0;
        stepClk();
        stepClk();
        checkOutput("mc_cnt_restart", 32'(led), 32'h0);
        checkOutput("mc_tick_lo0", 32'(tick), 32'h0);
        stepClk();
        stepClk();
        checkOutput("mc_tick_lo1", 32'(tick), 32'h0);
        stepClk();
        checkOutput("mc_tick_hi", 32'(tick), 32'h1);
        stepClk();
        checkOutput("mc_cnt1", 32'(led), 32'h1);

        // Bouncing scanner
        resetDut(1'b1, 2'd1);
        stepClk();
        stepClk();
        checkOutput("scan_pos0", 32'(led), 32'h1);
        for (int j = 0; j < 10; j++) begin
            repeat (4) stepClk();
            checkOutput("scan_seq", 32'(led), 32'(scanExp[j]));
        end

        // Freeze mid-scan, then resume from the same position and prescale phase
        enable = 1'b0;
        repeat (20) begin
            stepClk();
            checkOutput("frz_led", 32'(led), 32'h04);
            checkOutput("frz_tick", 32'(tick), 32'h0);
        end
        enable = 1'b1;
        stepClk();
        checkOutput("res_tick_lo0", 32'(tick), 32'h0);
        stepClk();
        checkOutput("res_tick_lo1", 32'(tick), 32'h0);
        stepClk();
        checkOutput("res_tick_hi", 32'(tick), 32'h1);
        stepClk();
        checkOutput("res_led", 32'(led), 32'h08);

        // Asynchronous reset clears outputs before the next edge
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_led", 32'(led), 32'h0);
        checkOutput("async_rst_tick", 32'(tick), 32'h0);

        // Breathing duty measured with the pattern frozen
        resetDut(1'b0, 2'd2);
        stepClk();
        countLit(lit);
        checkOutput("br_d0", 32'(lit), 32'd0);
        advanceStrobes(3);
        countLit(lit);
        checkOutput("br_d3", 32'(lit), 32'(LIT_D3));
        advanceStrobes(2);
        countLit(lit);
        checkOutput("br_d5", 32'(lit), 32'(LIT_D5));
        advanceStrobes(10);
        countLit(lit);
        checkOutput("br_d15", 32'(lit), 32'(LIT_D15));
        advanceStrobes(1);
        countLit(lit);
        checkOutput("br_d14_down", 32'(lit), 32'(LIT_D14));
        advanceStrobes(14);
        countLit(lit);
        checkOutput("br_d0_bottom", 32'(lit), 32'd0);
        advanceStrobes(1);
        countLit(lit);
        checkOutput("br_d1_up", 32'(lit), 32'(LIT_D1));

        // Off mode blanks the LEDs
        applyStimulus(1'b1, 2'd3);
        stepClk();
        stepClk();
        countLit(lit);
        checkOutput("off_lit", 32'(lit), 32'd0);
        checkOutput("off_led", 32'(led), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
